// File: rtl/if_id_queue_pkg.sv
// Shared widths and the entry layout for the IF->ID instruction queue.
// The package stands in for the global instruction and queue-depth constants.
package if_id_queue_pkg;

   localparam int INST_W      = 32;
   localparam int INST_ADDR_W = 32;
   localparam int QUEUE_DEPTH = 4;

   typedef struct packed {
      logic [INST_W-1:0]      inst;
      logic [INST_ADDR_W-1:0] pc_plus4;
   } entry_t;

   localparam entry_t NOP_ENTRY = '0;

endpackage

// File: rtl/if_id_queue.sv
// Circular-buffer queue decoupling instruction fetch from decode.
// Head outputs come only from registered state; a full queue holds IF.
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int DEPTH = QUEUE_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [INST_W-1:0]      in_inst,
   input  logic [INST_ADDR_W-1:0] in_pc_plus4,
   input  logic                   flush,
   input  logic                   id_ready,
   output logic                   if_hold,
   output logic                   out_valid,
   output logic [INST_W-1:0]      out_inst,
   output logic [INST_ADDR_W-1:0] out_pc_plus4
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   entry_t            mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   entry_t            head;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // A full queue refuses the word even when a pop frees a slot; IF re-presents it.
   assign push = in_valid & ~full & ~flush;
   assign pop  = ~empty & id_ready & ~flush;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         unique case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Storage is never cleared; an empty count masks stale entries.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[wr_ptr] <= '{inst: in_inst, pc_plus4: in_pc_plus4};
      end
   end

   always_comb begin
      head = NOP_ENTRY;
      if (!empty) head = mem[rd_ptr];
   end

   assign if_hold      = full;
   assign out_valid    = ~empty;
   assign out_inst     = head.inst;
   assign out_pc_plus4 = head.pc_plus4;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based model.
module tb_if_id_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_inst;
   logic [31:0] in_pc_plus4;
   logic        flush;
   logic        id_ready;
   logic        if_hold;
   logic        out_valid;
   logic [31:0] out_inst;
   logic [31:0] out_pc_plus4;

   int pass_cnt  = 0;
   int total_cnt = 0;
   bit model_chk = 1'b0;

   logic [63:0] model_q [$];

   if_id_queue #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_inst      (in_inst),
      .in_pc_plus4  (in_pc_plus4),
      .flush        (flush),
      .id_ready     (id_ready),
      .if_hold      (if_hold),
      .out_valid    (out_valid),
      .out_inst     (out_inst),
      .out_pc_plus4 (out_pc_plus4)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference: an ordered list of {inst, pc_plus4}; a full list turns the
   // incoming word away even if the head leaves in the same cycle.
   always @(posedge clk) begin
      if (rst || flush) begin
         model_q.delete();
      end else begin
         bit was_full;
         was_full = (model_q.size() == DEPTH);
         if (id_ready && model_q.size() != 0) void'(model_q.pop_front());
         if (in_valid && !was_full) model_q.push_back({in_inst, in_pc_plus4});
      end
   end

   always @(negedge clk) begin
      if (model_chk) begin
         logic [63:0] head;
         head = (model_q.size() != 0) ? model_q[0] : 64'd0;
         check("m_valid", {63'd0, out_valid}, {63'd0, model_q.size() != 0});
         check("m_hold",  {63'd0, if_hold},   {63'd0, model_q.size() == DEPTH});
         check("m_inst",  {32'd0, out_inst},     {32'd0, head[63:32]});
         check("m_pc",    {32'd0, out_pc_plus4}, {32'd0, head[31:0]});
      end
   end

   task automatic cyc(input logic r, input logic v, input logic [31:0] i,
                      input logic [31:0] p, input logic f, input logic rd);
      rst = r; in_valid = v; in_inst = i; in_pc_plus4 = p; flush = f; id_ready = rd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] drain_exp [6];
      logic [31:0] w;
      logic [31:0] wpc;
      bit          accept;

      rst = 1'b1; in_valid = 1'b1; in_inst = 32'hEE; in_pc_plus4 = 32'h4;
      flush = 1'b0; id_ready = 1'b0;

      // Reset held two cycles with a word on the input
      cyc(1, 1, 32'hEE, 32'h4, 0, 0);
      cyc(1, 1, 32'hEE, 32'h4, 0, 0);
      model_chk = 1'b1;
      check("rst_valid", {63'd0, out_valid}, 64'd0);
      check("rst_inst",  {32'd0, out_inst}, 64'd0);
      check("rst_pc",    {32'd0, out_pc_plus4}, 64'd0);
      check("rst_hold",  {63'd0, if_hold}, 64'd0);

      // Fill to full with decode stalled
      cyc(0, 1, 32'h11, 32'd4, 0, 0);
      check("lat_valid", {63'd0, out_valid}, 64'd1);
      check("lat_inst",  {32'd0, out_inst}, 64'h11);
      check("lat_pc",    {32'd0, out_pc_plus4}, 64'd4);
      cyc(0, 1, 32'h22, 32'd8, 0, 0);
      cyc(0, 1, 32'h33, 32'd12, 0, 0);
      check("fill3_hold", {63'd0, if_hold}, 64'd0);
      cyc(0, 1, 32'h44, 32'd16, 0, 0);
      check("full_hold", {63'd0, if_hold}, 64'd1);
      cyc(0, 1, 32'h55, 32'd20, 0, 0);
      check("full_head", {32'd0, out_inst}, 64'h11);
      check("full_hold2", {63'd0, if_hold}, 64'd1);

      // Drain while IF streams; a held word is re-presented until accepted
      drain_exp[0] = 32'h11; drain_exp[1] = 32'h22; drain_exp[2] = 32'h33;
      drain_exp[3] = 32'h44; drain_exp[4] = 32'h55; drain_exp[5] = 32'h66;
      w = 32'h55; wpc = 32'd20;
      for (int k = 0; k < 6; k++) begin
         check("drain_valid", {63'd0, out_valid}, 64'd1);
         check("drain_order", {32'd0, out_inst}, {32'd0, drain_exp[k]});
         accept = !if_hold;
         cyc(0, 1, w, wpc, 0, 1);
         if (accept) begin
            w = w + 32'h11;
            wpc = wpc + 32'd4;
         end
      end

      // Flush with three queued and a simultaneous push and pop
      cyc(0, 0, 32'h0, 32'h0, 1, 0);
      check("clr_valid", {63'd0, out_valid}, 64'd0);
      cyc(0, 1, 32'hA1, 32'h100, 0, 0);
      cyc(0, 1, 32'hA2, 32'h104, 0, 0);
      cyc(0, 1, 32'hA3, 32'h108, 0, 0);
      cyc(0, 1, 32'h99, 32'h10C, 1, 1);
      check("flush_valid", {63'd0, out_valid}, 64'd0);
      check("flush_inst",  {32'd0, out_inst}, 64'd0);
      check("flush_hold",  {63'd0, if_hold}, 64'd0);
      cyc(0, 0, 32'h0, 32'h0, 0, 1);
      check("flush_no99", {63'd0, out_valid}, 64'd0);

      // Pass-through on an empty queue
      cyc(0, 1, 32'hAB, 32'h200, 0, 1);
      check("pt_valid", {63'd0, out_valid}, 64'd1);
      check("pt_inst",  {32'd0, out_inst}, 64'hAB);
      cyc(0, 0, 32'h0, 32'h0, 0, 1);
      check("pt_gone", {63'd0, out_valid}, 64'd0);

      // Underflow attempts leave the queue empty and coherent
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 32'h0, 32'h0, 0, 1);
         check("uf_valid", {63'd0, out_valid}, 64'd0);
      end
      cyc(0, 1, 32'hC1, 32'h300, 0, 0);
      cyc(0, 1, 32'hC2, 32'h304, 0, 0);
      check("uf_head", {32'd0, out_inst}, 64'hC1);

      // Reset mid-operation overrides push
      cyc(1, 1, 32'hC3, 32'h308, 0, 1);
      check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      check("mid_rst_pc", {32'd0, out_pc_plus4}, 64'd0);

      // Randomized traffic, checked by the model every cycle
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 9) < 7),
             $urandom,
             $urandom,
             ($urandom_range(0, 24) == 0),
             ($urandom_range(0, 9) < 5));
      end
      cyc(0, 0, 32'h0, 32'h0, 0, 0);
      @(negedge clk);
      model_chk = 1'b0;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of instruction entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high (`RstEnable).
REQ-004 SHALL have port in_valid  input  1  IF ce; fetched word present this cycle.
REQ-005 SHALL have port in_inst  input  `InstWidth  instruction word from instruction ROM for current pc.
REQ-006 SHALL have port in_pc_plus4  input  `InstAddrWidth  pc_plus4 from IF for in_inst.
REQ-007 SHALL have port flush  input  1  branch taken (`BranchEnable); discard all queued and incoming words.
REQ-008 SHALL have port id_ready  input  1  ID consumes head entry this cycle.
REQ-009 SHALL have port if_hold  output  1  drives IF is_hold; `HoldEnable when queue full.
REQ-010 SHALL have port out_valid  output  1  head entry valid.
REQ-011 SHALL have port out_inst  output  `InstWidth  head instruction.
REQ-012 SHALL have port out_pc_plus4  output  `InstAddrWidth  head pc_plus4.

Function
REQ-013 SHALL store entries in a circular buffer with wr_ptr, rd_ptr (log2 DEPTH bits, wrap modulo DEPTH) and count (log2 DEPTH + 1 bits, range 0..DEPTH).
REQ-014 SHALL push {in_inst, in_pc_plus4} when in_valid=1, count<DEPTH, flush=0; wr_ptr increments.
REQ-015 SHALL pop when out_valid=1, id_ready=1, flush=0; rd_ptr increments.
REQ-016 SHALL on simultaneous push and pop leave count unchanged, both pointers advance.
REQ-017 SHALL refuse push when count=DEPTH even if pop occurs same cycle; word is not lost because IF holds pc and re-presents it.
REQ-018 SHALL assert if_hold combinationally iff count=DEPTH.
REQ-019 SHALL drive out_valid = (count!=0), out_inst/out_pc_plus4 = entry at rd_ptr; purely from registered state (no in_* to out_* combinational path).
REQ-020 SHALL output out_inst=0 (NOP) and out_pc_plus4=0 when count=0.
REQ-021 SHALL give latency of exactly one cycle: word pushed at edge N appears at outputs after edge N when queue was empty.
REQ-022 SHALL on flush=1 set count=0, rd_ptr=wr_ptr=0 at next edge; flush overrides simultaneous push and pop; id_ready ignored.
REQ-023 SHALL ignore id_ready while count=0 (no underflow, pointers unchanged).
REQ-024 SHALL preserve FIFO order across pointer wrap-around.

Reset
REQ-025 SHALL on rst=1 at a clock edge set count=0, rd_ptr=0, wr_ptr=0, regardless of in_valid, flush, id_ready.
REQ-026 SHALL after reset present out_valid=0, out_inst=0, out_pc_plus4=0, if_hold=0.
REQ-027 SHALL treat rst asserted mid-operation identically to flush plus pointer clear; storage contents need not be cleared.
REQ-028 SHALL have rst priority over flush, flush over push/pop.

Structure
REQ-029 SHALL take `InstWidth, `InstAddrWidth, `RstEnable, `HoldEnable, `BranchEnable from the shared define.v; no new global constants except `QueueDepth default 4 added there.
REQ-030 SHALL be a single module; storage an internal register array; no sub-modules required (dffe not used, pointers held directly).

Verification
REQ-031 Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_inst=0, if_hold=0 after release.
REQ-032 Fill: id_ready=0, push inst 0x11,0x22,0x33,0x44 (pc_plus4 4,8,12,16) -> if_hold=1 after 4th edge; 5th word 0x55 not accepted; out_inst=0x11.
REQ-033 Drain with wrap: from full, id_ready=1, in_valid=1 streaming 0x55.. -> outputs in order 0x11,0x22,0x33,0x44,0x55 with no gap or duplicate; pointers wrap past 3.
REQ-034 Flush: 3 entries queued, flush=1 with in_valid=1 (0x99) and id_ready=1 -> next cycle out_valid=0, count=0, 0x99 absent.
REQ-035 Pass-through: empty queue, push 0xAB at edge N, id_ready=1 -> out_inst=0xAB valid after edge N, popped at N+1, out_valid=0 after.
REQ-036 Underflow: empty queue, id_ready=1 for 3 cycles, in_valid=0 -> out_valid stays 0, pointers stay 0.
